// File: rtl/ex_pkg.sv
// Shared definitions for the MIPS execute stage: ALU operation enum, funct and
// opcode encodings, multiplier state type and small combinational helpers.
package ex_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned CNT_W   = 5;

    // R-type funct codes
    localparam logic [FUNCT_W-1:0] FUNCT_ADD  = 6'h20;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB  = 6'h22;
    localparam logic [FUNCT_W-1:0] FUNCT_AND  = 6'h24;
    localparam logic [FUNCT_W-1:0] FUNCT_OR   = 6'h25;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT  = 6'h2A;
    localparam logic [FUNCT_W-1:0] FUNCT_MULT = 6'h18;
    localparam logic [FUNCT_W-1:0] FUNCT_MFHI = 6'h10;
    localparam logic [FUNCT_W-1:0] FUNCT_MFLO = 6'h12;

    // I-type opcodes
    localparam logic [FUNCT_W-1:0] OP_ANDI = 6'h0C;
    localparam logic [FUNCT_W-1:0] OP_ORI  = 6'h0D;
    localparam logic [FUNCT_W-1:0] OP_SLTI = 6'h0A;

    typedef enum logic [3:0] {
        ALU_ZERO,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_MULT,
        ALU_MFHI,
        ALU_MFLO
    } alu_op_e;

    typedef enum logic {
        MULT_IDLE,
        MULT_BUSY
    } mult_state_e;

    // ALU operation from the ID/EX class plus funct/opcode
    function automatic alu_op_e alu_decode(input logic [1:0]         alu_class,
                                           input logic [FUNCT_W-1:0] funct,
                                           input logic [FUNCT_W-1:0] opcode);
        alu_op_e op;
        op = ALU_ZERO;
        case (alu_class)
            2'b00: op = ALU_ADD;
            2'b01: op = ALU_SUB;
            2'b10: begin
                case (funct)
                    FUNCT_ADD:  op = ALU_ADD;
                    FUNCT_SUB:  op = ALU_SUB;
                    FUNCT_AND:  op = ALU_AND;
                    FUNCT_OR:   op = ALU_OR;
                    FUNCT_SLT:  op = ALU_SLT;
                    FUNCT_MULT: op = ALU_MULT;
                    FUNCT_MFHI: op = ALU_MFHI;
                    FUNCT_MFLO: op = ALU_MFLO;
                    default:    op = ALU_ZERO;
                endcase
            end
            default: begin
                case (opcode)
                    OP_ANDI: op = ALU_AND;
                    OP_ORI:  op = ALU_OR;
                    OP_SLTI: op = ALU_SLT;
                    default: op = ALU_ZERO;
                endcase
            end
        endcase
        return op;
    endfunction

    // Operand forwarding: MEM wins over WB, register 0 is never forwarded
    function automatic logic [DATA_W-1:0] fwd_sel(input logic [REG_W-1:0]  idx,
                                                  input logic [DATA_W-1:0] id_data,
                                                  input logic              mem_we,
                                                  input logic [REG_W-1:0]  mem_rd,
                                                  input logic [DATA_W-1:0] mem_res,
                                                  input logic              wb_we,
                                                  input logic [REG_W-1:0]  wb_rd,
                                                  input logic [DATA_W-1:0] wb_res);
        logic [DATA_W-1:0] val;
        val = id_data;
        if (mem_we && (mem_rd != '0) && (mem_rd == idx)) begin
            val = mem_res;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == idx)) begin
            val = wb_res;
        end
        return val;
    endfunction

    // Two's-complement magnitude; 0x80000000 maps to itself as an unsigned value
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? (~x + DATA_W'(1)) : x;
    endfunction

endpackage

// File: rtl/mult_seq.sv
// Iterative signed 32x32 shift-add multiplier, one partial product per cycle.
// Ports: clk, reset_n (async active-low); start captures operands a/b in IDLE;
// busy is high in BUSY; done_c pulses in the final step (counter 31) together
// with the finished signed 64-bit product on product_c; cnt is the step counter.
module mult_seq
    import ex_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                busy,
    output logic                done_c,
    output logic [CNT_W-1:0]    cnt,
    output logic [2*DATA_W-1:0] product_c
);

    mult_state_e         state;
    mult_state_e         state_nxt;
    logic [DATA_W-1:0]   mcand;
    logic [DATA_W-1:0]   mplier;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] acc_nxt;
    logic                neg;

    // Accumulator after the current step; also feeds the final product
    always_comb begin
        acc_nxt = acc;
        if (mplier[cnt]) begin
            acc_nxt = acc + ((2*DATA_W)'(mcand) << cnt);
        end
    end

    assign product_c = neg ? (~acc_nxt + (2*DATA_W)'(1)) : acc_nxt;
    assign busy      = (state == MULT_BUSY);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= MULT_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and completion strobe
    always_comb begin
        state_nxt = state;
        done_c    = 1'b0;
        case (state)
            MULT_IDLE: begin
                if (start) begin
                    state_nxt = MULT_BUSY;
                end
            end
            MULT_BUSY: begin
                if (cnt == CNT_W'(DATA_W-1)) begin
                    done_c    = 1'b1;
                    state_nxt = MULT_IDLE;
                end
            end
            default: state_nxt = MULT_IDLE;
        endcase
    end

    // Operand capture and shift-add datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
        end else if ((state == MULT_IDLE) && start) begin
            mcand  <= abs_val(a);
            mplier <= abs_val(b);
            neg    <= a[DATA_W-1] ^ b[DATA_W-1];
            acc    <= '0;
            cnt    <= '0;
        end else if (state == MULT_BUSY) begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(1);     // wraps 31 -> 0 on completion
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the five-stage MIPS pipeline: forwarding from MEM/WB, ALU,
// beq resolution and the EX/MEM pipeline register.
// Config macro EX_MULT_EN: adds the iterative multiplier, HI/LO and stall;
// without it mult/mfhi/mflo produce 0 as single-cycle ops and stall is 0.
// Ports: clk, reset_n (async active-low); ID/EX control, data, indices and
// funct/opcode; MEM and WB forwarding sources; stall (combinational, holds the
// front end); registered EX/MEM outputs ex_*.
module ex_stage
    import ex_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               RegDst,
    input  logic               ALUSrc,
    input  logic               MemToReg,
    input  logic               RegWrite,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic               Branch,
    input  logic [1:0]         ALUOp,
    input  logic [DATA_W-1:0]  pc_plus4,
    input  logic [DATA_W-1:0]  rs_data,
    input  logic [DATA_W-1:0]  rt_data,
    input  logic [DATA_W-1:0]  sign_ext,
    input  logic [REG_W-1:0]   rs,
    input  logic [REG_W-1:0]   rt,
    input  logic [REG_W-1:0]   rd,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [FUNCT_W-1:0] opcode,
    input  logic               mem_RegWrite,
    input  logic [REG_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0]  mem_result,
    input  logic               wb_RegWrite,
    input  logic [REG_W-1:0]   wb_rd,
    input  logic [DATA_W-1:0]  wb_result,
    output logic               stall,
    output logic               ex_MemToReg,
    output logic               ex_RegWrite,
    output logic               ex_MemRead,
    output logic               ex_MemWrite,
    output logic               ex_branch_taken,
    output logic [DATA_W-1:0]  ex_alu_result,
    output logic [DATA_W-1:0]  ex_store_data,
    output logic [DATA_W-1:0]  ex_branch_target,
    output logic [REG_W-1:0]   ex_dest
);

    alu_op_e           op;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] opnd_b;
    logic [DATA_W-1:0] alu_res;
    logic              bubble;

    assign op     = alu_decode(ALUOp, funct, opcode);
    assign opnd_a = fwd_sel(rs, rs_data, mem_RegWrite, mem_rd, mem_result,
                            wb_RegWrite, wb_rd, wb_result);
    assign fwd_b  = fwd_sel(rt, rt_data, mem_RegWrite, mem_rd, mem_result,
                            wb_RegWrite, wb_rd, wb_result);
    assign opnd_b = ALUSrc ? sign_ext : fwd_b;

`ifdef EX_MULT_EN
    logic                mult_start;
    logic                mult_busy;
    logic                mult_done;
    logic [CNT_W-1:0]    mult_cnt;
    logic [2*DATA_W-1:0] product;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    logic                stall_raw;

    // A mult held in ID/EX must not restart while the previous one runs
    assign mult_start = (op == ALU_MULT) && !mult_busy;

    mult_seq u_mult (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (mult_start),
        .a         (opnd_a),
        .b         (fwd_b),
        .busy      (mult_busy),
        .done_c    (mult_done),
        .cnt       (mult_cnt),
        .product_c (product)
    );

    // Stall from start through counter 30; the counter-31 cycle lets mult retire
    assign stall_raw = mult_start || (mult_busy && (mult_cnt != CNT_W'(DATA_W-1)));
    assign stall     = reset_n & stall_raw;
    assign bubble    = stall_raw || (op == ALU_MULT);

    // HI/LO take the product on the final step's edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi <= '0;
            lo <= '0;
        end else if (mult_done) begin
            hi <= product[2*DATA_W-1:DATA_W];
            lo <= product[DATA_W-1:0];
        end
    end
`else
    assign stall  = 1'b0;
    assign bubble = 1'b0;
`endif

    // ALU
    always_comb begin
        alu_res = '0;
        case (op)
            ALU_ADD: alu_res = opnd_a + opnd_b;
            ALU_SUB: alu_res = opnd_a - opnd_b;
            ALU_AND: alu_res = opnd_a & opnd_b;
            ALU_OR:  alu_res = opnd_a | opnd_b;
            ALU_SLT: alu_res = DATA_W'($signed(opnd_a) < $signed(opnd_b));
`ifdef EX_MULT_EN
            ALU_MFHI: alu_res = hi;
            ALU_MFLO: alu_res = lo;
`endif
            default: alu_res = '0;
        endcase
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_MemToReg      <= 1'b0;
            ex_RegWrite      <= 1'b0;
            ex_MemRead       <= 1'b0;
            ex_MemWrite      <= 1'b0;
            ex_branch_taken  <= 1'b0;
            ex_alu_result    <= '0;
            ex_store_data    <= '0;
            ex_branch_target <= '0;
            ex_dest          <= '0;
        end else if (bubble) begin
            ex_MemToReg      <= 1'b0;
            ex_RegWrite      <= 1'b0;
            ex_MemRead       <= 1'b0;
            ex_MemWrite      <= 1'b0;
            ex_branch_taken  <= 1'b0;
            ex_alu_result    <= '0;
            ex_store_data    <= '0;
            ex_branch_target <= '0;
            ex_dest          <= '0;
        end else begin
            ex_MemToReg      <= MemToReg;
            ex_RegWrite      <= RegWrite;
            ex_MemRead       <= MemRead;
            ex_MemWrite      <= MemWrite;
            ex_branch_taken  <= Branch && (opnd_a == opnd_b);
            ex_alu_result    <= alu_res;
            ex_store_data    <= fwd_b;
            ex_branch_target <= pc_plus4 + (sign_ext << 2);
            ex_dest          <= RegDst ? rd : rt;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: table of single-cycle vectors through a
// scoreboard, plus multiply, HI/LO and reset sequences.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch;
    logic [1:0]  ALUOp;
    logic [31:0] pc_plus4, rs_data, rt_data, sign_ext;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct, opcode;
    logic        mem_RegWrite;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_RegWrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        stall;
    logic        ex_MemToReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_branch_taken;
    logic [31:0] ex_alu_result, ex_store_data, ex_branch_target;
    logic [4:0]  ex_dest;

    ex_stage dut (
        .clk(clk), .reset_n(reset_n),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp),
        .pc_plus4(pc_plus4), .rs_data(rs_data), .rt_data(rt_data), .sign_ext(sign_ext),
        .rs(rs), .rt(rt), .rd(rd), .funct(funct), .opcode(opcode),
        .mem_RegWrite(mem_RegWrite), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .stall(stall),
        .ex_MemToReg(ex_MemToReg), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_branch_taken(ex_branch_taken),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_branch_target(ex_branch_target), .ex_dest(ex_dest)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch;
        logic [1:0]  aluop;
        logic [31:0] pc, rsd, rtd, se;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  funct, opcode;
        logic        mwe;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic        wwe;
        logic [4:0]  wrd;
        logic [31:0] wres;
    } in_t;

    // ctl = {MemToReg, RegWrite, MemRead, MemWrite, branch_taken}
    typedef struct packed {
        logic [4:0]  ctl;
        logic [31:0] alu, store, target;
        logic [4:0]  dest;
    } exp_t;

    typedef struct {
        string name;
        in_t   i;
        exp_t  e;
    } vec_t;

    vec_t  tbl[$];
    exp_t  sb[$];
    string sb_name[$];
    int    checks = 0;
    int    errors = 0;

    function automatic exp_t mkexp(input logic [4:0] ctl, input logic [31:0] alu,
                                   input logic [31:0] store, input logic [31:0] target,
                                   input logic [4:0] dest);
        exp_t e;
        e.ctl = ctl; e.alu = alu; e.store = store; e.target = target; e.dest = dest;
        return e;
    endfunction

    function automatic in_t rtype(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        in_t v;
        v = '0;
        v.regdst = 1'b1; v.regwrite = 1'b1; v.aluop = 2'b10; v.funct = f;
        v.rs = 5'd1; v.rt = 5'd2; v.rd = 5'd3; v.rsd = a; v.rtd = b;
        return v;
    endfunction

    function automatic in_t itype(input logic [5:0] op, input logic [31:0] a, input logic [31:0] imm);
        in_t v;
        v = '0;
        v.alusrc = 1'b1; v.regwrite = 1'b1; v.aluop = 2'b11; v.opcode = op;
        v.rs = 5'd1; v.rt = 5'd4; v.rsd = a; v.se = imm;
        return v;
    endfunction

    task automatic drive(input in_t v);
        RegDst = v.regdst; ALUSrc = v.alusrc; MemToReg = v.memtoreg; RegWrite = v.regwrite;
        MemRead = v.memread; MemWrite = v.memwrite; Branch = v.branch; ALUOp = v.aluop;
        pc_plus4 = v.pc; rs_data = v.rsd; rt_data = v.rtd; sign_ext = v.se;
        rs = v.rs; rt = v.rt; rd = v.rd; funct = v.funct; opcode = v.opcode;
        mem_RegWrite = v.mwe; mem_rd = v.mrd; mem_result = v.mres;
        wb_RegWrite = v.wwe; wb_rd = v.wrd; wb_result = v.wres;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input exp_t e);
        chk({name, ".ctl"}, 64'({ex_MemToReg, ex_RegWrite, ex_MemRead, ex_MemWrite,
                                  ex_branch_taken}), 64'(e.ctl));
        chk({name, ".alu"},    64'(ex_alu_result),    64'(e.alu));
        chk({name, ".store"},  64'(ex_store_data),    64'(e.store));
        chk({name, ".target"}, 64'(ex_branch_target), 64'(e.target));
        chk({name, ".dest"},   64'(ex_dest),          64'(e.dest));
    endtask

    // One single-cycle instruction: drive mid-cycle, expect result after the edge
    task automatic apply(input string name, input in_t v, input exp_t e);
        exp_t  exp_e;
        string n;
        @(negedge clk);
        drive(v);
        sb.push_back(e);
        sb_name.push_back(name);
        #1;
        chk({name, ".stall"}, 64'(stall), 64'(0));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({name, ".scoreboard_empty"}, 64'(1), 64'(0));
        end else begin
            exp_e = sb.pop_front();
            n     = sb_name.pop_front();
            check_out(n, exp_e);
        end
    endtask

`ifdef EX_MULT_EN
    // Multiply, count stall cycles, check bubbles, then read LO and HI back
    task automatic do_mult(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        @(negedge clk);
        drive(rtype(6'h18, a, b));
        #1;
        n = 0;
        while (stall && n < 40) begin
            n++;
            @(posedge clk);
            #1;
            // Retarget MEM forwarding onto rs mid-multiply; must not disturb the result
            if (n == 2) begin
                mem_RegWrite = 1'b1; mem_rd = 5'd1; mem_result = 32'd100;
            end
            check_out({name, ".bubble"}, '0);
            @(negedge clk);
            #1;
        end
        chk({name, ".stall_cycles"}, 64'(n), 64'(32));
        @(posedge clk);
        #1;
        check_out({name, ".retire"}, '0);
        apply({name, ".mflo"}, rtype(6'h12, 32'h0, 32'h0), mkexp(5'b01000, exp_lo, 32'h0, 32'h0, 5'd3));
        apply({name, ".mfhi"}, rtype(6'h10, 32'h0, 32'h0), mkexp(5'b01000, exp_hi, 32'h0, 32'h0, 5'd3));
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t r;
        in_t  v;

        // Vector table
        r.name = "fwd_prio"; v = rtype(6'h20, 32'h99, 32'd3);
        v.rs = 5'd5; v.rt = 5'd6; v.rd = 5'd7;
        v.mwe = 1'b1; v.mrd = 5'd5; v.mres = 32'h10; v.wwe = 1'b1; v.wrd = 5'd5; v.wres = 32'h20;
        r.i = v; r.e = mkexp(5'b01000, 32'h13, 32'd3, 32'h0, 5'd7); tbl.push_back(r);

        r.name = "rd0_nofwd"; v = rtype(6'h20, 32'h0, 32'd4);
        v.rs = 5'd0; v.mwe = 1'b1; v.mrd = 5'd0; v.mres = 32'hFF;
        r.i = v; r.e = mkexp(5'b01000, 32'h4, 32'h4, 32'h0, 5'd3); tbl.push_back(r);

        r.name = "wb_fwd"; v = rtype(6'h22, 32'h10, 32'h1);
        v.rt = 5'd8; v.wwe = 1'b1; v.wrd = 5'd8; v.wres = 32'h50;
        v.mwe = 1'b1; v.mrd = 5'd9; v.mres = 32'h77;
        r.i = v; r.e = mkexp(5'b01000, 32'hFFFFFFC0, 32'h50, 32'h0, 5'd3); tbl.push_back(r);

        r.name = "beq_taken"; v = '0;
        v.branch = 1'b1; v.aluop = 2'b01; v.rs = 5'd1; v.rt = 5'd2;
        v.rsd = 32'd7; v.rtd = 32'd7; v.se = 32'd4; v.pc = 32'h100;
        r.i = v; r.e = mkexp(5'b00001, 32'h0, 32'd7, 32'h110, 5'd2); tbl.push_back(r);

        r.name = "beq_not"; v.rtd = 32'd8; v.se = 32'hFFFFFFFF;
        r.i = v; r.e = mkexp(5'b00000, 32'hFFFFFFFF, 32'd8, 32'hFC, 5'd2); tbl.push_back(r);

        r.name = "beq_fwd"; v = '0;
        v.branch = 1'b1; v.aluop = 2'b01; v.rs = 5'd1; v.rt = 5'd2;
        v.rsd = 32'd0; v.rtd = 32'd9; v.mwe = 1'b1; v.mrd = 5'd1; v.mres = 32'd9;
        r.i = v; r.e = mkexp(5'b00001, 32'h0, 32'd9, 32'h0, 5'd2); tbl.push_back(r);

        r.name = "lw_add_wrap"; v = '0;
        v.alusrc = 1'b1; v.memtoreg = 1'b1; v.regwrite = 1'b1; v.memread = 1'b1;
        v.rs = 5'd1; v.rt = 5'd4; v.rsd = 32'h7FFFFFFF; v.rtd = 32'h55; v.se = 32'd1;
        r.i = v; r.e = mkexp(5'b11100, 32'h80000000, 32'h55, 32'h4, 5'd4); tbl.push_back(r);

        r.name = "slt_neg"; r.i = rtype(6'h2A, 32'hFFFFFFFF, 32'd1);
        r.e = mkexp(5'b01000, 32'd1, 32'd1, 32'h0, 5'd3); tbl.push_back(r);

        r.name = "slt_pos"; r.i = rtype(6'h2A, 32'd1, 32'hFFFFFFFF);
        r.e = mkexp(5'b01000, 32'd0, 32'hFFFFFFFF, 32'h0, 5'd3); tbl.push_back(r);

        r.name = "ori"; r.i = itype(6'h0D, 32'hF0, 32'h0F);
        r.e = mkexp(5'b01000, 32'hFF, 32'h0, 32'h3C, 5'd4); tbl.push_back(r);

        r.name = "andi"; r.i = itype(6'h0C, 32'hF0F0, 32'hFF);
        r.e = mkexp(5'b01000, 32'hF0, 32'h0, 32'h3FC, 5'd4); tbl.push_back(r);

        r.name = "slti"; r.i = itype(6'h0A, 32'd5, 32'hFFFFFFFE);
        r.e = mkexp(5'b01000, 32'd0, 32'h0, 32'hFFFFFFF8, 5'd4); tbl.push_back(r);

        r.name = "and"; r.i = rtype(6'h24, 32'hFF00FF00, 32'h0FF00FF0);
        r.e = mkexp(5'b01000, 32'h0F000F00, 32'h0FF00FF0, 32'h0, 5'd3); tbl.push_back(r);

        r.name = "or"; r.i = rtype(6'h25, 32'hF0000000, 32'hF);
        r.e = mkexp(5'b01000, 32'hF000000F, 32'hF, 32'h0, 5'd3); tbl.push_back(r);

        r.name = "bad_funct_sw"; v = rtype(6'h00, 32'd5, 32'd6);
        v.regwrite = 1'b0; v.memwrite = 1'b1;
        r.i = v; r.e = mkexp(5'b00010, 32'h0, 32'd6, 32'h0, 5'd3); tbl.push_back(r);

        r.name = "sub_wrap"; v = '0;
        v.aluop = 2'b01; v.regwrite = 1'b1; v.rs = 5'd1; v.rt = 5'd2; v.rtd = 32'd1;
        r.i = v; r.e = mkexp(5'b01000, 32'hFFFFFFFF, 32'd1, 32'h0, 5'd2); tbl.push_back(r);

        r.name = "bad_opcode"; r.i = itype(6'h08, 32'd5, 32'd3);
        r.e = mkexp(5'b01000, 32'h0, 32'h0, 32'hC, 5'd4); tbl.push_back(r);

        // Reset state
        reset_n = 1'b0;
        drive('0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.stall", 64'(stall), 64'(0));
        check_out("reset", '0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[k]) begin
            apply(tbl[k].name, tbl[k].i, tbl[k].e);
        end

        // Asynchronous reset clears a populated EX/MEM register
        apply("pre_reset", tbl[6].i, tbl[6].e);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_out("async_reset", '0);
        @(negedge clk);
        reset_n = 1'b1;

`ifdef EX_MULT_EN
        do_mult("mul_m3x5", 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        do_mult("mul_min_sq", 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        do_mult("mul_max_min", 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);

        // Reset at counter 10 aborts the multiply; HI/LO must read 0 afterwards
        @(negedge clk);
        drive(rtype(6'h18, 32'd7, 32'd9));
        repeat (11) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_mult_reset.stall", 64'(stall), 64'(0));
        check_out("mid_mult_reset", '0);
        @(negedge clk);
        drive(rtype(6'h10, 32'h0, 32'h0));
        reset_n = 1'b1;
        apply("post_reset.mflo", rtype(6'h12, 32'h0, 32'h0), mkexp(5'b01000, 32'h0, 32'h0, 32'h0, 5'd3));
        apply("post_reset.mfhi", rtype(6'h10, 32'h0, 32'h0), mkexp(5'b01000, 32'h0, 32'h0, 32'h0, 5'd3));
`else
        // Without the multiplier, mult/mfhi/mflo are single-cycle and yield 0
        apply("mult_off", rtype(6'h18, 32'hFFFFFFFD, 32'd5), mkexp(5'b01000, 32'h0, 32'd5, 32'h0, 5'd3));
        apply("mflo_off", rtype(6'h12, 32'h0, 32'h0), mkexp(5'b01000, 32'h0, 32'h0, 32'h0, 5'd3));
        apply("mfhi_off", rtype(6'h10, 32'h0, 32'h0), mkexp(5'b01000, 32'h0, 32'h0, 32'h0, 5'd3));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
